// File: rtl/sine_period_meter.sv
// sine_period_meter
// Watches an offset-binary sine stream, finds rising midscale crossings with
// hysteresis, and reports the period (in valid samples) averaged over
// 2^AVG_LOG2 periods, the signed error against a target period, a lock flag
// and a sticky timeout when no crossing is seen for 2^CNT_W-1 valid samples.

module sine_period_meter #(
    parameter int DATA_W   = 8,
    parameter int MID      = 128,
    parameter int HYST     = 8,
    parameter int CNT_W    = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       sample_in,
    input  logic                    sample_valid,
    input  logic [7:0]              target_period,
    output logic [CNT_W-1:0]        period_out,
    output logic                    period_valid,
    output logic signed [CNT_W:0]   error,
    output logic                    lock,
    output logic                    timeout
);

    localparam int ACC_W  = CNT_W + AVG_LOG2;
    localparam int NPER_W = AVG_LOG2 + 1;

    localparam logic [DATA_W-1:0] LO_THR     = DATA_W'(MID - HYST);
    localparam logic [DATA_W-1:0] HI_THR     = DATA_W'(MID + HYST);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    // cnt value one below saturation: the next non-crossing sample times out
    localparam logic [CNT_W-1:0]  CNT_LAST   = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [ACC_W-1:0]  ACC_ZERO   = {ACC_W{1'b0}};
    localparam logic [NPER_W-1:0] NPER_ZERO  = {NPER_W{1'b0}};
    localparam logic [NPER_W-1:0] NPER_ONE   = {{(NPER_W-1){1'b0}}, 1'b1};
    localparam logic [NPER_W-1:0] NPER_FULL  = {1'b1, {(NPER_W-1){1'b0}}};
    localparam logic [CNT_W:0]    ERR_ZERO   = {(CNT_W+1){1'b0}};
    localparam logic [CNT_W:0]    ERR_ONE    = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0]    ERR_NEG1   = {(CNT_W+1){1'b1}};
    localparam logic [1:0]        LOCK_ZERO  = 2'd0;
    localparam logic [1:0]        LOCK_ONE   = 2'd1;
    localparam logic [1:0]        LOCK_SAT   = 2'd2;

    typedef enum logic [0:0] {
        SEEK_LOW  = 1'b0,
        SEEK_HIGH = 1'b1
    } state_t;

    // registered state
    state_t              state_q,        state_d;
    logic                first_q,        first_d;
    logic [CNT_W-1:0]    cnt_q,          cnt_d;
    logic [ACC_W-1:0]    acc_q,          acc_d;
    logic [NPER_W-1:0]   nper_q,         nper_d;
    logic [1:0]          lock_cnt_q,     lock_cnt_d;
    logic [CNT_W-1:0]    period_q,       period_d;
    logic [CNT_W:0]      error_q,        error_d;
    logic                period_valid_q, period_valid_d;
    logic                lock_q,         lock_d;
    logic                timeout_q,      timeout_d;

    // combinational helpers
    logic                lo_hit_s;
    logic                hi_hit_s;
    logic                crossing_s;
    logic                timeout_hit_s;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [ACC_W-1:0]    acc_sum_s;
    logic [NPER_W-1:0]   nper_inc_s;
    logic                window_done_s;
    logic [CNT_W-1:0]    avg_s;
    logic [CNT_W:0]      diff_s;
    logic                in_tol_s;
    logic [1:0]          lock_cnt_inc_s;

    // Crossing detection, interval arithmetic and result preparation
    always_comb begin
        lo_hit_s       = (sample_in <= LO_THR);
        hi_hit_s       = (sample_in >= HI_THR);
        crossing_s     = sample_valid && (state_q == SEEK_HIGH) && hi_hit_s;
        cnt_inc_s      = cnt_q + CNT_ONE;
        // a crossing always wins over saturation on the same sample
        timeout_hit_s  = sample_valid && !crossing_s && (cnt_q == CNT_LAST);
        // interval = cnt + 1, which is exactly cnt_inc_s
        acc_sum_s      = acc_q + ACC_W'(cnt_inc_s);
        nper_inc_s     = nper_q + NPER_ONE;
        window_done_s  = crossing_s && !first_q && (nper_inc_s == NPER_FULL);
        avg_s          = acc_sum_s[ACC_W-1:AVG_LOG2];
        diff_s         = {1'b0, avg_s} - (CNT_W+1)'(target_period);
        in_tol_s       = (diff_s == ERR_ZERO) || (diff_s == ERR_ONE) ||
                         (diff_s == ERR_NEG1);
        if (lock_cnt_q == LOCK_SAT) begin
            lock_cnt_inc_s = LOCK_SAT;
        end else begin
            lock_cnt_inc_s = lock_cnt_q + LOCK_ONE;
        end
    end

    // Next-state logic for the crossing FSM, averaging window, lock and timeout
    always_comb begin
        state_d        = state_q;
        first_d        = first_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        nper_d         = nper_q;
        lock_cnt_d     = lock_cnt_q;
        period_d       = period_q;
        error_d        = error_q;
        period_valid_d = 1'b0;
        lock_d         = lock_q;
        timeout_d      = timeout_q;

        if (sample_valid) begin
            if (crossing_s) begin
                state_d   = SEEK_LOW;
                cnt_d     = CNT_ZERO;
                timeout_d = 1'b0;
                if (first_q) begin
                    // first crossing only anchors the interval measurement
                    first_d = 1'b0;
                end else if (window_done_s) begin
                    acc_d          = ACC_ZERO;
                    nper_d         = NPER_ZERO;
                    period_d       = avg_s;
                    error_d        = diff_s;
                    period_valid_d = 1'b1;
                    if (in_tol_s) begin
                        lock_cnt_d = lock_cnt_inc_s;
                        lock_d     = (lock_cnt_inc_s == LOCK_SAT);
                    end else begin
                        lock_cnt_d = LOCK_ZERO;
                        lock_d     = 1'b0;
                    end
                end else begin
                    acc_d  = acc_sum_s;
                    nper_d = nper_inc_s;
                end
            end else if (timeout_hit_s) begin
                // lost signal: restart measurement, keep last result visible
                state_d    = SEEK_LOW;
                first_d    = 1'b1;
                cnt_d      = CNT_ZERO;
                acc_d      = ACC_ZERO;
                nper_d     = NPER_ZERO;
                lock_cnt_d = LOCK_ZERO;
                lock_d     = 1'b0;
                timeout_d  = 1'b1;
            end else begin
                cnt_d = cnt_inc_s;
                case (state_q)
                    SEEK_LOW: begin
                        if (lo_hit_s) begin
                            state_d = SEEK_HIGH;
                        end else begin
                            state_d = SEEK_LOW;
                        end
                    end
                    SEEK_HIGH: begin
                        state_d = SEEK_HIGH;
                    end
                    default: begin
                        state_d = SEEK_LOW;
                    end
                endcase
            end
        end else begin
            // invalid cycle: hold everything, period_valid already cleared
            state_d = state_q;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= SEEK_LOW;
            first_q        <= 1'b1;
            cnt_q          <= CNT_ZERO;
            acc_q          <= ACC_ZERO;
            nper_q         <= NPER_ZERO;
            lock_cnt_q     <= LOCK_ZERO;
            period_q       <= CNT_ZERO;
            error_q        <= ERR_ZERO;
            period_valid_q <= 1'b0;
            lock_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            first_q        <= first_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            nper_q         <= nper_d;
            lock_cnt_q     <= lock_cnt_d;
            period_q       <= period_d;
            error_q        <= error_d;
            period_valid_q <= period_valid_d;
            lock_q         <= lock_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period_out   = period_q;
    assign error        = error_q;
    assign period_valid = period_valid_q;
    assign lock         = lock_q;
    assign timeout      = timeout_q;

    sine_period_meter_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk          (clk),
        .reset        (reset),
        .period_valid (period_valid_q),
        .timeout      (timeout_q),
        .lock         (lock_q),
        .error        (error_q)
    );

endmodule

// Output invariants of sine_period_meter
module sine_period_meter_chk #(
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           reset,
    input logic           period_valid,
    input logic           timeout,
    input logic           lock,
    input logic [CNT_W:0] error
);

    // a result is produced by a crossing, which always clears timeout
    a_pv_no_timeout: assert property (@(posedge clk) disable iff (!reset)
        period_valid |-> !timeout);

    // results need several crossings, so pulses never run back to back
    a_pv_single: assert property (@(posedge clk) disable iff (!reset)
        period_valid |=> !period_valid);

    // lock is only ever held with an in-tolerance error
    a_lock_tol: assert property (@(posedge clk) disable iff (!reset)
        lock |-> ((error == {(CNT_W+1){1'b0}}) ||
                  (error == {{CNT_W{1'b0}}, 1'b1}) ||
                  (error == {(CNT_W+1){1'b1}})));

endmodule

// File: tb/tb_sine_period_meter.sv
// Bench for sine_period_meter (CNT_W=8 so the timeout is reachable quickly).
// A crossing-index reference model predicts every output on every cycle;
// a table of wave scenarios and a few hand sequences check constants.

module tb_sine_period_meter;

    localparam int CNT_W = 8;
    localparam int HI    = 136;
    localparam int LO    = 120;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [7:0]         sample_in = 8'd0;
    logic               sample_valid = 1'b0;
    logic [7:0]         target_period = 8'd16;
    logic [CNT_W-1:0]   period_out;
    logic               period_valid;
    logic signed [CNT_W:0] error;
    logic               lock;
    logic               timeout;

    always #5 clk = ~clk;

    sine_period_meter #(
        .DATA_W   (8),
        .MID      (128),
        .HYST     (8),
        .CNT_W    (CNT_W),
        .AVG_LOG2 (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .target_period (target_period),
        .period_out    (period_out),
        .period_valid  (period_valid),
        .error         (error),
        .lock          (lock),
        .timeout       (timeout)
    );

    int checks = 0;
    int errors = 0;

    // reference model: crossings tracked by valid-sample index
    bit m_armed, m_first;
    int m_vidx, m_anchor, m_sum, m_n, m_streak;
    int exp_period, exp_err;
    bit exp_lock, exp_to, exp_pv;
    int wave_ph = 0;

    task automatic model_reset();
        m_armed = 0; m_first = 1; m_vidx = 0; m_anchor = 0;
        m_sum = 0; m_n = 0; m_streak = 0;
        exp_period = 0; exp_err = 0; exp_lock = 0; exp_to = 0; exp_pv = 0;
    endtask

    task automatic model_step(input int s, input bit v);
        int d;
        exp_pv = 0;
        if (v) begin
            m_vidx++;
            if (m_armed && s >= HI) begin
                m_armed = 0;
                exp_to = 0;
                if (m_first) begin
                    m_first = 0;
                end else begin
                    m_sum += m_vidx - m_anchor;
                    m_n++;
                    if (m_n == 4) begin
                        exp_period = m_sum / 4;
                        exp_err = exp_period - int'(target_period);
                        d = (exp_err < 0) ? -exp_err : exp_err;
                        if (d <= 1) m_streak++; else m_streak = 0;
                        exp_lock = (m_streak >= 2);
                        exp_pv = 1;
                        m_sum = 0; m_n = 0;
                    end
                end
                m_anchor = m_vidx;
            end else if (m_vidx - m_anchor == 255) begin
                exp_to = 1; m_armed = 0; m_first = 1;
                m_sum = 0; m_n = 0; m_streak = 0; exp_lock = 0;
                m_anchor = m_vidx;
            end else if (s <= LO) begin
                m_armed = 1;
            end
        end
    endtask

    task automatic check_model();
        checks++;
        if (int'(period_out) != exp_period || int'(error) != exp_err ||
            lock != exp_lock || timeout != exp_to || period_valid != exp_pv) begin
            errors++;
            $display("FAIL model t=%0t got per=%0d err=%0d lock=%0b to=%0b pv=%0b want per=%0d err=%0d lock=%0b to=%0b pv=%0b",
                     $time, period_out, error, lock, timeout, period_valid,
                     exp_period, exp_err, exp_lock, exp_to, exp_pv);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step(input logic [7:0] s, input logic v);
        sample_in = s;
        sample_valid = v;
        @(posedge clk);
        model_step(int'(s), v);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sample_valid = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_model();
        reset = 1'b1;
    endtask

    function automatic logic [7:0] wave_val(input int ph, input int p, input bit noise);
        int h;
        h = p / 2;
        if (ph == 0) return 8'($urandom_range(0, LO));
        if (ph == h) return 8'($urandom_range(HI, 255));
        if (noise && ($urandom % 3 == 0)) return 8'($urandom_range(122, 134));
        if (ph < h) return 8'($urandom_range(0, LO));
        return 8'($urandom_range(HI, 255));
    endfunction

    // run a wave until nres model results have been produced
    task automatic run_wave(input int p, input bit vtog, input bit noise,
                            input bit gaps, input int nres);
        int got, cyc;
        bit v, tog;
        got = 0; cyc = 0; tog = 1;
        while (got < nres && cyc < 4000) begin
            if (vtog) v = tog;
            else if (gaps) v = ($urandom % 4 != 0);
            else v = 1;
            tog = ~tog;
            step(wave_val(wave_ph, p, noise), v);
            if (v) wave_ph = (wave_ph + 1) % p;
            if (exp_pv) got++;
            cyc++;
        end
        check_val("result_budget", got, nres);
    endtask

    // run exactly n valid wave samples
    task automatic run_samples(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            step(wave_val(wave_ph, p, 0), 1'b1);
            wave_ph = (wave_ph + 1) % p;
        end
    endtask

    typedef struct {
        int p;
        int target;
        bit noise;
        bit vtog;
        int nres;
        int exp_period;
        int exp_err;
        bit exp_lock;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{16, 16, 0, 0, 1, 16,  0, 0};
        tbl[1] = '{16, 16, 0, 0, 2, 16,  0, 1};
        tbl[2] = '{20, 16, 0, 0, 3, 20,  4, 0};
        tbl[3] = '{16, 16, 1, 0, 2, 16,  0, 1};
        tbl[4] = '{16, 16, 0, 1, 2, 16,  0, 1};
        tbl[5] = '{15, 16, 0, 0, 2, 15, -1, 1};
        tbl[6] = '{17, 16, 0, 0, 2, 17,  1, 1};
        tbl[7] = '{18, 16, 0, 0, 3, 18,  2, 0};
        tbl[8] = '{12, 20, 1, 1, 2, 12, -8, 0};

        model_reset();
        do_reset();
        check_val("reset_period", int'(period_out), 0);
        check_val("reset_flags", int'({period_valid, lock, timeout}), 0);

        // table-driven scenarios, each from a fresh reset
        for (int i = 0; i < 9; i++) begin
            target_period = 8'(tbl[i].target);
            do_reset();
            wave_ph = 0;
            run_wave(tbl[i].p, tbl[i].vtog, tbl[i].noise, 0, tbl[i].nres);
            check_val($sformatf("tbl%0d_period", i), int'(period_out), tbl[i].exp_period);
            check_val($sformatf("tbl%0d_error", i), int'(error), tbl[i].exp_err);
            check_val($sformatf("tbl%0d_lock", i), int'(lock), int'(tbl[i].exp_lock));
        end

        // first-result latency: crossing 5 is valid sample 73, next 64 later
        target_period = 8'd16;
        do_reset();
        wave_ph = 0;
        for (int k = 1; k <= 137; k++) begin
            step(wave_val(wave_ph, 16, 0), 1'b1);
            wave_ph = (wave_ph + 1) % 16;
            if (k == 72 || k == 136) check_val($sformatf("pv_before_%0d", k), int'(period_valid), 0);
            if (k == 73 || k == 137) check_val($sformatf("pv_at_%0d", k), int'(period_valid), 1);
        end

        // retarget: 20 vs 16 never locks, then target 20 locks after two results
        do_reset();
        wave_ph = 0;
        run_wave(20, 0, 0, 0, 2);
        check_val("rt_err", int'(error), 4);
        check_val("rt_lock0", int'(lock), 0);
        target_period = 8'd20;
        run_wave(20, 0, 0, 0, 1);
        check_val("rt_lock1", int'(lock), 0);
        run_wave(20, 0, 0, 0, 1);
        check_val("rt_lock2", int'(lock), 1);
        check_val("rt_err0", int'(error), 0);

        // timeout after 255 samples with no crossing, then recovery
        target_period = 8'd16;
        do_reset();
        wave_ph = 0;
        run_wave(16, 0, 0, 0, 2);
        check_val("to_prelock", int'(lock), 1);
        for (int k = 1; k <= 255; k++) begin
            step(8'd200, 1'b1);
            if (k == 254) check_val("to_before", int'(timeout), 0);
        end
        check_val("to_set", int'(timeout), 1);
        check_val("to_hold_period", int'(period_out), 16);
        check_val("to_lock_clr", int'(lock), 0);
        wave_ph = 0;
        for (int k = 1; k <= 73; k++) begin
            step(wave_val(wave_ph, 16, 0), 1'b1);
            wave_ph = (wave_ph + 1) % 16;
            if (k == 8) check_val("to_sticky", int'(timeout), 1);
            if (k == 9) check_val("to_cleared", int'(timeout), 0);
            if (k == 72) check_val("to_pv_early", int'(period_valid), 0);
        end
        check_val("to_pv_resume", int'(period_valid), 1);
        check_val("to_period_resume", int'(period_out), 16);

        // reset after three accumulated periods discards everything
        do_reset();
        wave_ph = 0;
        run_wave(16, 0, 0, 0, 2);
        run_samples(16, 48);
        do_reset();
        check_val("rst_period", int'(period_out), 0);
        check_val("rst_error", int'(error), 0);
        check_val("rst_flags", int'({period_valid, lock, timeout}), 0);
        wave_ph = 0;
        for (int k = 1; k <= 73; k++) begin
            step(wave_val(wave_ph, 16, 0), 1'b1);
            wave_ph = (wave_ph + 1) % 16;
            if (k == 72) check_val("rst_pv_early", int'(period_valid), 0);
        end
        check_val("rst_pv_fresh", int'(period_valid), 1);

        // randomized periods, targets and valid gaps against the model
        for (int r = 0; r < 6; r++) begin
            int p;
            p = int'($urandom_range(4, 40));
            target_period = 8'($urandom_range(p - 2, p + 2));
            if (r == 0) do_reset();
            run_wave(p, 0, 1, 1, 3);
        end

        // fully random samples, including long droughts, against the model
        for (int k = 0; k < 800; k++) begin
            if (k < 400) step(8'($urandom_range(0, 255)), 1'($urandom % 2));
            else step(8'($urandom_range(100, 200)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
